// File: rtl/pending_request_dispatcher_pkg.sv
// -----------------------------------------------------------------------------
// prd_pkg
// Shared declarations for the pending request dispatcher:
//   - prd_state_e : two-state dispatcher FSM encoding (IDLE / OFFER)
//   - idx_width() : width of a binary source index, never less than 1 bit
// -----------------------------------------------------------------------------
package prd_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } prd_state_e;

  // A single source still needs one index bit so od_bin is never zero-width.
  function automatic int idx_width(input int width);
    if (width > 1) begin
      return $clog2(width);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/pending_request_dispatcher_if.sv
// -----------------------------------------------------------------------------
// pending_request_dispatcher_if
// Bundles the request side and the offer/handshake side of the dispatcher.
//   id_req     : per-source set event (1 sets pending bit)
//   id_mask    : per-source dispatch eligibility
//   id_flush   : synchronous clear of all pending bits and the offer
//   id_ready   : consumer accepts the current offer
//   od_valid   : offer valid
//   od_bin     : offered source index
//   od_filt    : offered source one-hot
//   od_pending : registered pending vector
//   od_drop    : one-cycle pulse when a request hit an already pending bit
// Modports:
//   master : event source / consumer side (drives id_*, observes od_*)
//   slave  : dispatcher side (observes id_*, drives od_*)
// -----------------------------------------------------------------------------
interface pending_request_dispatcher_if
  import prd_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int WIDTH_W = idx_width(WIDTH)
) ();

  logic [WIDTH-1:0]   id_req;
  logic [WIDTH-1:0]   id_mask;
  logic               id_flush;
  logic               id_ready;
  logic               od_valid;
  logic [WIDTH_W-1:0] od_bin;
  logic [WIDTH-1:0]   od_filt;
  logic [WIDTH-1:0]   od_pending;
  logic               od_drop;

  modport master (
    output id_req, id_mask, id_flush, id_ready,
    input  od_valid, od_bin, od_filt, od_pending, od_drop
  );

  modport slave (
    input  id_req, id_mask, id_flush, id_ready,
    output od_valid, od_bin, od_filt, od_pending, od_drop
  );

endinterface

// File: rtl/pending_request_dispatcher_priority_encoder.sv
// -----------------------------------------------------------------------------
// priority_encoder
// Purely combinational highest-index-wins encoder.
//   id_cand  in  WIDTH    candidate vector
//   od_valid out 1        any candidate present
//   od_bin   out WIDTH_W  index of the highest set candidate (0 if none)
//   od_filt  out WIDTH    one-hot of the winner (0 if none)
// -----------------------------------------------------------------------------
module priority_encoder
  import prd_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int WIDTH_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]   id_cand,
  output logic               od_valid,
  output logic [WIDTH_W-1:0] od_bin,
  output logic [WIDTH-1:0]   od_filt
);

  localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1'b1);

  logic [WIDTH_W-1:0] w_bin;

  // Ascending scan: a later (higher) set bit overrides earlier ones.
  always_comb begin
    w_bin = {WIDTH_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (id_cand[i]) begin
        w_bin = WIDTH_W'(i);
      end else begin
        w_bin = w_bin;
      end
    end
  end

  assign od_valid = |id_cand;
  assign od_bin   = w_bin;
  assign od_filt  = od_valid ? (LP_ONE << w_bin) : {WIDTH{1'b0}};

endmodule

// File: rtl/pending_request_dispatcher.sv
// -----------------------------------------------------------------------------
// pending_request_dispatcher
// Captures sticky request events from WIDTH sources, arbitrates the masked
// pending set by fixed priority (highest index wins) and presents the winner
// on a valid/ready handshake. The winner's pending bit clears on acceptance.
//   clk    in  1   clock, all state on the rising edge
//   rst_n  in  1   asynchronous active-low reset
//   bus    slave modport of pending_request_dispatcher_if
//          (id_req, id_mask, id_flush, id_ready in;
//           od_valid, od_bin, od_filt, od_pending, od_drop out)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module pending_request_dispatcher
  import prd_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int WIDTH_W = idx_width(WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pending_request_dispatcher_if.slave  bus
);

  prd_state_e         r_state;
  prd_state_e         w_state_nxt;
  logic [WIDTH-1:0]   r_pending;
  logic [WIDTH-1:0]   w_pending_nxt;
  logic               r_valid;
  logic [WIDTH_W-1:0] r_bin;
  logic [WIDTH-1:0]   r_filt;
  logic               r_drop;
  logic               w_drop_nxt;

  logic               w_accept;
  logic [WIDTH-1:0]   w_accept_oh;
  logic [WIDTH-1:0]   w_cand;
  logic               w_enc_valid;
  logic [WIDTH_W-1:0] w_enc_bin;
  logic [WIDTH-1:0]   w_enc_filt;
  logic               w_load;
  logic               w_clear;

  assign w_accept    = r_valid & bus.id_ready;
  assign w_accept_oh = w_accept ? r_filt : {WIDTH{1'b0}};

  // Excluding the accepted bit lets the same term serve both the idle scan
  // and the back-to-back re-arbitration on acceptance.
  assign w_cand = r_pending & bus.id_mask & ~w_accept_oh;

  priority_encoder #(
    .WIDTH   (WIDTH),
    .WIDTH_W (WIDTH_W)
  ) u_enc (
    .id_cand  (w_cand),
    .od_valid (w_enc_valid),
    .od_bin   (w_enc_bin),
    .od_filt  (w_enc_filt)
  );

  // Pending update: flush beats a new event, a new event beats acceptance.
  always_comb begin
    w_pending_nxt = r_pending;
    if (bus.id_flush) begin
      w_pending_nxt = {WIDTH{1'b0}};
    end else begin
      w_pending_nxt = (r_pending & ~w_accept_oh) | bus.id_req;
    end
  end

  // A request landing on a bit that stays pending is coalesced and flagged.
  always_comb begin
    w_drop_nxt = 1'b0;
    if (bus.id_flush) begin
      w_drop_nxt = 1'b0;
    end else begin
      w_drop_nxt = |(bus.id_req & r_pending & ~w_accept_oh);
    end
  end

  // Dispatcher next-state and offer load/clear decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.id_flush) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_enc_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_OFFER;
        end else begin
          w_clear     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (bus.id_flush) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_accept && w_enc_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_OFFER;
        end else if (w_accept) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          // Unaccepted offer is held stable regardless of mask/pending churn.
          w_state_nxt = ST_OFFER;
        end
      end
      default: begin
        w_clear     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pending vector and drop pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= {WIDTH{1'b0}};
      r_drop    <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

  // Offer registers: load a new winner, clear when idle, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_bin   <= {WIDTH_W{1'b0}};
      r_filt  <= {WIDTH{1'b0}};
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_bin   <= w_enc_bin;
      r_filt  <= w_enc_filt;
    end else if (w_clear) begin
      r_valid <= 1'b0;
      r_bin   <= {WIDTH_W{1'b0}};
      r_filt  <= {WIDTH{1'b0}};
    end else begin
      r_valid <= r_valid;
      r_bin   <= r_bin;
      r_filt  <= r_filt;
    end
  end

  assign bus.od_valid   = r_valid;
  assign bus.od_bin     = r_bin;
  assign bus.od_filt    = r_filt;
  assign bus.od_pending = r_pending;
  assign bus.od_drop    = r_drop;

endmodule
